// File: rtl/fft_block_sequencer_pkg.sv
// Shared constants for the FFT front-end sequencer: sample widths, legal transform
// sizes, counter width and FSM state encoding.
package fft_block_sequencer_pkg;

   localparam int unsigned FFT_MAN_WIDTH = 16;
   localparam int unsigned FFT_EXP_WIDTH = 6;
   localparam int unsigned CNT_WIDTH     = 12;

   localparam logic [3:0] LDN_MIN = 4'd6;
   localparam logic [3:0] LDN_MAX = 4'd11;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_STREAM = 2'd1;
   localparam logic [1:0] ST_DRAIN  = 2'd2;

   function automatic logic ldn_legal(input logic [3:0] ldn);
      return (ldn >= LDN_MIN) && (ldn <= LDN_MAX);
   endfunction

   // N = 2^ldn; ldn <= 11 keeps N inside the 12-bit counters.
   function automatic logic [CNT_WIDTH-1:0] block_len(input logic [3:0] ldn);
      return CNT_WIDTH'(1) << ldn;
   endfunction

endpackage

// File: rtl/fft_block_sequencer_if.sv
// Bundle of the sequencer's control, upstream stream, pipeline-entry and pipeline-exit
// signals. master = sequencer side, slave = surrounding environment.
interface fft_block_sequencer_if
   import fft_block_sequencer_pkg::*;
#(
   parameter int unsigned MAN_WIDTH = FFT_MAN_WIDTH,
   parameter int unsigned EXP_WIDTH = FFT_EXP_WIDTH
);
   logic                 start_i;
   logic                 stop_i;
   logic [3:0]           cfg_ldn_i;
   logic                 in_valid_i;
   logic                 in_ready_o;
   logic [MAN_WIDTH-1:0] in_real_i;
   logic [MAN_WIDTH-1:0] in_imag_i;
   logic                 block_sync_o;
   logic                 stage_sync_o;
   logic                 data_val_o;
   logic [MAN_WIDTH-1:0] data_real_o;
   logic [MAN_WIDTH-1:0] data_imag_o;
   logic [EXP_WIDTH-1:0] data_exp_o;
   logic [3:0]           ldn_rg_o;
   logic                 out_val_i;
   logic                 out_block_sync_i;
   logic                 block_done_o;
   logic                 busy_o;
   logic                 cfg_err_o;
   logic                 sync_err_o;

   modport master (
      input  start_i, stop_i, cfg_ldn_i, in_valid_i, in_real_i, in_imag_i,
             out_val_i, out_block_sync_i,
      output in_ready_o, block_sync_o, stage_sync_o, data_val_o, data_real_o, data_imag_o,
             data_exp_o, ldn_rg_o, block_done_o, busy_o, cfg_err_o, sync_err_o
   );

   modport slave (
      output start_i, stop_i, cfg_ldn_i, in_valid_i, in_real_i, in_imag_i,
             out_val_i, out_block_sync_i,
      input  in_ready_o, block_sync_o, stage_sync_o, data_val_o, data_real_o, data_imag_o,
             data_exp_o, ldn_rg_o, block_done_o, busy_o, cfg_err_o, sync_err_o
   );

endinterface

// File: rtl/fft_block_sequencer_exit.sv
// Pipeline-exit monitor: counts exit samples per block, flags framing violations and
// emits a registered done pulse when the N-th sample of a block leaves the pipeline.
module fft_exit_monitor
   import fft_block_sequencer_pkg::*;
(
   input  logic                 clk_sys,
   input  logic                 rst_sys_n,
   input  logic                 i_out_val,
   input  logic                 i_out_block_sync,
   input  logic [CNT_WIDTH-1:0] i_block_len,
   output logic                 o_done,
   output logic                 o_err
);

   logic [CNT_WIDTH-1:0] r_out_cnt;
   logic [CNT_WIDTH-1:0] w_out_cnt_d;
   logic                 r_done;
   logic                 w_done_d;
   logic                 r_err;
   logic                 w_err_d;

   // Next exit count; an early sync restarts the block and is reported.
   always_comb begin
      w_out_cnt_d = r_out_cnt;
      w_done_d    = 1'b0;
      w_err_d     = 1'b0;
      if (i_out_val) begin
         if (i_out_block_sync) begin
            w_err_d     = (r_out_cnt != '0);
            w_out_cnt_d = CNT_WIDTH'(1);
         end else if (r_out_cnt != '0) begin
            w_out_cnt_d = r_out_cnt + CNT_WIDTH'(1);
         end else begin
            w_err_d = 1'b1;
         end
         if (w_out_cnt_d == i_block_len) begin
            w_done_d    = 1'b1;
            w_out_cnt_d = '0;
         end
      end
   end

   // Exit counter and registered pulses.
   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         r_out_cnt <= '0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_out_cnt <= w_out_cnt_d;
         r_done    <= w_done_d;
         r_err     <= w_err_d;
      end
   end

   assign o_done = r_done;
   assign o_err  = r_err;

endmodule

// File: rtl/fft_block_sequencer.sv
// Front-end sequencer for the radix-4 FFT: frames upstream samples into 2^ldn blocks,
// bounds blocks in flight using the exit monitor's done pulses, and sequences start/stop.
module fft_block_sequencer
   import fft_block_sequencer_pkg::*;
#(
   parameter int unsigned MAN_WIDTH    = FFT_MAN_WIDTH,
   parameter int unsigned EXP_WIDTH    = FFT_EXP_WIDTH,
   parameter int unsigned MAX_INFLIGHT = 2
) (
   input logic                   clk_sys,
   input logic                   rst_sys_n,
   fft_block_sequencer_if.master bus
);

   logic [1:0]           r_state, w_state_d;
   logic [3:0]           r_ldn, w_ldn_d;
   logic [CNT_WIDTH-1:0] r_pos, w_pos_d;
   logic [1:0]           r_inflight, w_inflight_d;
   logic                 r_stop_pend, w_stop_pend_d;
   logic                 r_cfg_err, w_cfg_err_d;
   logic                 r_uflow_err, w_uflow_err_d;
   logic                 r_val, r_bsync;
   logic [MAN_WIDTH-1:0] r_real, r_imag;

   logic [CNT_WIDTH-1:0] w_n;
   logic                 w_last, w_ready, w_xfer, w_admit, w_mon_done, w_mon_err;

   assign w_n     = block_len(r_ldn);
   assign w_last  = (r_pos == w_n - CNT_WIDTH'(1));
   // A new block is only opened when there is room in flight and no stop is queued.
   assign w_ready = (r_state == ST_STREAM) &&
                    ((r_pos != '0) || ((r_inflight < 2'(MAX_INFLIGHT)) && !r_stop_pend));
   assign w_xfer  = bus.in_valid_i & w_ready;
   assign w_admit = w_xfer & (r_pos == '0);

   fft_exit_monitor u_exit (
      .clk_sys          (clk_sys),
      .rst_sys_n        (rst_sys_n),
      .i_out_val        (bus.out_val_i),
      .i_out_block_sync (bus.out_block_sync_i),
      .i_block_len      (w_n),
      .o_done           (w_mon_done),
      .o_err            (w_mon_err)
   );

   // FSM, position counter and stop sequencing.
   always_comb begin
      w_state_d     = r_state;
      w_ldn_d       = r_ldn;
      w_pos_d       = r_pos;
      w_stop_pend_d = r_stop_pend;
      w_cfg_err_d   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_stop_pend_d = 1'b0;
            if (bus.start_i) begin
               if (ldn_legal(bus.cfg_ldn_i)) begin
                  w_ldn_d   = bus.cfg_ldn_i;
                  w_pos_d   = '0;
                  w_state_d = ST_STREAM;
               end else begin
                  w_cfg_err_d = 1'b1;
               end
            end
         end
         ST_STREAM: begin
            if (bus.stop_i) w_stop_pend_d = 1'b1;
            if (w_xfer) w_pos_d = w_last ? '0 : r_pos + CNT_WIDTH'(1);
            // Leave only on a block boundary: either idle at position 0 or just closed N-1.
            if (bus.stop_i || r_stop_pend) begin
               if (w_xfer ? w_last : (r_pos == '0)) w_state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (r_inflight == '0) begin
               w_state_d     = ST_IDLE;
               w_stop_pend_d = 1'b0;
            end
         end
         default: w_state_d = ST_IDLE;
      endcase
   end

   // Blocks in flight: +1 on admit, -1 on exit done, saturating at 0 with an error.
   always_comb begin
      w_inflight_d  = r_inflight;
      w_uflow_err_d = 1'b0;
      case ({w_admit, w_mon_done})
         2'b10: w_inflight_d = r_inflight + 2'd1;
         2'b01: begin
            if (r_inflight == '0) w_uflow_err_d = 1'b1;
            else                  w_inflight_d  = r_inflight - 2'd1;
         end
         default: w_inflight_d = r_inflight;
      endcase
   end

   // State registers and the registered pipeline-entry outputs.
   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         r_state     <= ST_IDLE;
         r_ldn       <= LDN_MIN;
         r_pos       <= '0;
         r_inflight  <= '0;
         r_stop_pend <= 1'b0;
         r_cfg_err   <= 1'b0;
         r_uflow_err <= 1'b0;
         r_val       <= 1'b0;
         r_bsync     <= 1'b0;
         r_real      <= '0;
         r_imag      <= '0;
      end else begin
         r_state     <= w_state_d;
         r_ldn       <= w_ldn_d;
         r_pos       <= w_pos_d;
         r_inflight  <= w_inflight_d;
         r_stop_pend <= w_stop_pend_d;
         r_cfg_err   <= w_cfg_err_d;
         r_uflow_err <= w_uflow_err_d;
         r_val       <= w_xfer;
         r_bsync     <= w_admit;
         r_real      <= w_xfer ? bus.in_real_i : '0;
         r_imag      <= w_xfer ? bus.in_imag_i : '0;
      end
   end

   assign bus.in_ready_o   = w_ready;
   assign bus.data_val_o   = r_val;
   assign bus.block_sync_o = r_bsync;
   assign bus.stage_sync_o = r_bsync;
   assign bus.data_real_o  = r_real;
   assign bus.data_imag_o  = r_imag;
   assign bus.data_exp_o   = {EXP_WIDTH{1'b0}};
   assign bus.ldn_rg_o     = r_ldn;
   assign bus.block_done_o = w_mon_done;
   assign bus.busy_o       = (r_state != ST_IDLE);
   assign bus.cfg_err_o    = r_cfg_err;
   assign bus.sync_err_o   = w_mon_err | r_uflow_err;

endmodule
